// File: rtl/fg_ip_packet_sink.sv
// fg_ip_packet_sink: receive-side sink for flow-generator IP traffic.
//
// Accepts one IP header, then consumes the AXI-stream payload up to tlast,
// counting payload bytes from tkeep. It then presents one status record per
// packet: flow index, byte count and error flags. It also keeps aggregate
// packet, byte and error counters.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   input_ip_hdr_*                header handshake and fields (length, source, dest)
//   input_ip_payload_*            payload stream; tdata is ignored, tuser sampled on tlast
//   output_stat_*                 status record: src index, bytes, error {user, addr, len}
//   local_ip                      this node's IP address (static)
//   rx_pkt_count/byte/err_count   aggregate counters, wrap at 2^32
//   busy                          high whenever a packet is in progress
module fg_ip_packet_sink #(
    parameter int unsigned SRC_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [31:0] IP_PREFIX  = 32'hc0a80100
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  input_ip_hdr_valid,
    output logic                  input_ip_hdr_ready,
    input  logic [15:0]           input_ip_length,
    input  logic [31:0]           input_ip_source_ip,
    input  logic [31:0]           input_ip_dest_ip,

    input  logic [DATA_WIDTH-1:0] input_ip_payload_tdata,
    input  logic [KEEP_WIDTH-1:0] input_ip_payload_tkeep,
    input  logic                  input_ip_payload_tvalid,
    output logic                  input_ip_payload_tready,
    input  logic                  input_ip_payload_tlast,
    input  logic                  input_ip_payload_tuser,

    output logic                  output_stat_valid,
    input  logic                  output_stat_ready,
    output logic [SRC_WIDTH-1:0]  output_stat_src,
    output logic [15:0]           output_stat_bytes,
    output logic [2:0]            output_stat_error,

    input  logic [31:0]           local_ip,

    output logic [31:0]           rx_pkt_count,
    output logic [31:0]           rx_byte_count,
    output logic [31:0]           rx_err_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StStatus
    } state_e;

    state_e state_q, state_d;

    // Keeps hdr_ready low while reset is asserted even though the state is idle.
    logic ready_en_q;

    logic [SRC_WIDTH-1:0] src_q;
    logic [15:0]          expected_q;
    logic                 addr_err_q;
    logic [15:0]          acc_q;

    logic [SRC_WIDTH-1:0] stat_src_q;
    logic [15:0]          stat_bytes_q;
    logic [2:0]           stat_error_q;

    logic [31:0] pkt_count_q;
    logic [31:0] byte_count_q;
    logic [31:0] err_count_q;

    logic        hdr_fire;
    logic        beat_fire;
    logic        last_fire;
    logic [15:0] beat_total;
    logic [2:0]  final_error;
    logic        addr_err_now;

    // tdata carries no information the sink needs.
    logic unused_tdata;
    assign unused_tdata = ^input_ip_payload_tdata;

    function automatic logic [15:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [15:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
            cnt = cnt + {15'd0, keep[i]};
        end
        return cnt;
    endfunction

    // Next-state and handshake outputs.
    always_comb begin
        state_d                 = state_q;
        input_ip_hdr_ready      = 1'b0;
        input_ip_payload_tready = 1'b0;
        output_stat_valid       = 1'b0;
        unique case (state_q)
            StIdle: begin
                input_ip_hdr_ready = ready_en_q;
                if (input_ip_hdr_valid && ready_en_q) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                input_ip_payload_tready = 1'b1;
                if (input_ip_payload_tvalid && input_ip_payload_tlast) begin
                    state_d = StStatus;
                end
            end
            StStatus: begin
                output_stat_valid = 1'b1;
                if (output_stat_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign hdr_fire  = input_ip_hdr_valid && input_ip_hdr_ready;
    assign beat_fire = input_ip_payload_tvalid && input_ip_payload_tready;
    assign last_fire = beat_fire && input_ip_payload_tlast;

    // Running total including the current beat; on tlast this is the packet total.
    assign beat_total = acc_q + popcount(input_ip_payload_tkeep);

    assign addr_err_now = (input_ip_dest_ip != local_ip) ||
                          (input_ip_source_ip[31:SRC_WIDTH] != IP_PREFIX[31:SRC_WIDTH]);

    assign final_error = {input_ip_payload_tuser, addr_err_q, (beat_total != expected_q)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Header latch and byte accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            expected_q <= '0;
            addr_err_q <= 1'b0;
            acc_q      <= '0;
        end else if (hdr_fire) begin
            src_q      <= input_ip_source_ip[SRC_WIDTH-1:0];
            expected_q <= input_ip_length - 16'd20;
            addr_err_q <= addr_err_now;
            acc_q      <= '0;
        end else if (beat_fire) begin
            acc_q      <= beat_total;
        end
    end

    // Status record; held until the next packet completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_src_q   <= '0;
            stat_bytes_q <= '0;
            stat_error_q <= '0;
        end else if (last_fire) begin
            stat_src_q   <= src_q;
            stat_bytes_q <= beat_total;
            stat_error_q <= final_error;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q  <= '0;
            byte_count_q <= '0;
            err_count_q  <= '0;
        end else if (last_fire) begin
            pkt_count_q  <= pkt_count_q + 32'd1;
            byte_count_q <= byte_count_q + {16'd0, beat_total};
            if (|final_error) begin
                err_count_q <= err_count_q + 32'd1;
            end
        end
    end

    assign output_stat_src   = stat_src_q;
    assign output_stat_bytes = stat_bytes_q;
    assign output_stat_error = stat_error_q;
    assign rx_pkt_count      = pkt_count_q;
    assign rx_byte_count     = byte_count_q;
    assign rx_err_count      = err_count_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: doc/fg_ip_packet_sink.md
Name: fg_ip_packet_sink

Overview:
Receive-side counterpart of the flow generator's IP packet generator. Accepts IP frames (header plus AXI-stream payload) from the IP stack and identifies the originating flow from the source IP. Checks addressing, length and error flags, and emits one status record per packet. Maintains aggregate packet, byte and error counters for the flow-generator statistics block.

Parameters:
SRC_WIDTH, 8, width of flow/source index; index = input_ip_source_ip[SRC_WIDTH-1:0]
DATA_WIDTH, 64, payload tdata width (multiple of 8)
KEEP_WIDTH, DATA_WIDTH/8, payload tkeep width
IP_PREFIX, 32'hc0a80100, required value of input_ip_source_ip[31:SRC_WIDTH]

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
input_ip_hdr_valid  in  1  header valid
input_ip_hdr_ready  out  1  header accept
input_ip_length  in  16  IP total length, header included
input_ip_source_ip  in  32  source IP
input_ip_dest_ip  in  32  destination IP
input_ip_payload_tdata  in  DATA_WIDTH  payload data (ignored)
input_ip_payload_tkeep  in  KEEP_WIDTH  byte enables
input_ip_payload_tvalid  in  1  beat valid
input_ip_payload_tready  out  1  beat accept
input_ip_payload_tlast  in  1  last beat
input_ip_payload_tuser  in  1  frame error, sampled on last beat
output_stat_valid  out  1  status record valid
output_stat_ready  in  1  status record accept
output_stat_src  out  SRC_WIDTH  flow index
output_stat_bytes  out  16  payload bytes received
output_stat_error  out  3  bit0 length mismatch, bit1 address mismatch, bit2 tuser
local_ip  in  32  this node's IP (static)
rx_pkt_count  out  32  packets completed
rx_byte_count  out  32  payload bytes completed
rx_err_count  out  32  packets with any error bit set
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE. All ready/valid outputs 0; stat fields 0; all counters 0; busy 0.
- States: IDLE, PAYLOAD, STATUS.
- IDLE:
  - hdr_ready = 1 and payload tready = 0.
  - On header handshake, latch src index, expected = length - 20 (16-bit modulo), addr_err = (dest_ip != local_ip) or (source_ip[31:SRC_WIDTH] != IP_PREFIX[31:SRC_WIDTH]).
  - Clear the byte accumulator; go to PAYLOAD next cycle.
- PAYLOAD:
  - hdr_ready = 0 and tready = 1.
  - Each accepted beat adds popcount(tkeep) to the 16-bit accumulator (wraps modulo 2^16).
  - On the tlast beat, compute the final byte total including that beat. Set len_err = (total != expected) and user_err = tuser.
  - Load the stat outputs, update counters that same edge, and go to STATUS.
  - Packets with errors are consumed fully, never dropped early.
- STATUS:
  - output_stat_valid = 1 with fields held stable.
  - On stat handshake, go to IDLE; hdr_ready reasserts the following cycle.
  - While output_stat_ready = 0, stall indefinitely: hdr_ready = 0, tready = 0.
- Latency:
  - Header accepted at cycle N gives tready = 1 at N+1.
  - tlast accepted at cycle M gives stat_valid = 1 at M+1.
  - Minimum packet period = 1 (hdr) + beats + 1 (status) cycles.
- Counters, updated on the tlast edge:
  - rx_pkt_count += 1.
  - rx_byte_count += total.
  - rx_err_count += 1 if any error bit is set.
  - All counters wrap at 2^32.
- Header valid while not in IDLE: ignored, not accepted. Payload beats in IDLE: not accepted (tready = 0).
- tuser on non-last beats: ignored.
- Reset mid-packet: immediate return to IDLE, counters cleared, partial packet discarded. Upstream must resynchronise.

Test Plan:
- local_ip=0xc0a80180; header src 0xc0a80105, dest 0xc0a80180, length 52; 4 beats tkeep 0xFF, tlast on beat 4, stat_ready=1 -> stat src=0x05, bytes=32, error=0; pkt=1, byte=32, err=0; stat_valid exactly 1 cycle after tlast.
- Same header with 3 beats, last tkeep 0x0F -> bytes=20, error=3'b001; err_count=1.
- dest_ip 0xc0a80181, correct length, 4 full beats -> all 4 beats accepted, error=3'b010. Repeat with src 0x0a000105 -> error=3'b010.
- tuser=1 on last beat of a correct 32-byte packet -> error=3'b100; tuser=1 on a middle beat only -> error=0.
- Hold stat_ready=0 for 5 cycles after tlast with the next header pending -> stat fields stable, hdr_ready=0, tready=0 throughout. Header accepted the cycle after stat handshake +1.
- Assert rst_n=0 after beat 2 of a 4-beat packet -> outputs and counters zero immediately. After release, a fresh 32-byte packet completes with bytes=32, pkt=1.
